lfsr_share_ctrl: RTL and testbench
==================================

Name: lfsr_share_ctrl

Overview:
Controller that owns one WIDTH-bit XNOR Fibonacci LFSR and shares it between NREQ requesters. Arbitration is round-robin. Before each grant the LFSR is advanced STEPS times, so successive consumers receive decorrelated words. The block also sequences seed loading and detects lock-up. It sits between the pseudo-random generator datapath and the blocks that consume random words.

Parameters:
WIDTH, 4, LFSR and data width (>=2)
TAPS, 4'b1100, tap mask; feedback = XNOR-reduce of (lfsr & TAPS)
NREQ, 4, number of requesters (>=2)
STEPS, 2, LFSR advances between grants (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester request, level, held until granted
gnt  output  NREQ  one-hot grant, one-cycle pulse
rnd_valid  output  1  high in the grant cycle; rnd_data valid
rnd_data  output  WIDTH  delivered random word; holds last value
seed_load  input  1  load seed into LFSR (accepted only in IDLE)
seed  input  WIDTH  seed value
busy  output  1  high in STEP and GRANT
lockup_err  output  1  sticky; set when an all-ones seed is rejected

Behaviour:
- Reset (async) values: lfsr=0, state=IDLE, rr_ptr=0, cnt=0, gnt=0, rnd_valid=0, rnd_data=0, busy=0, lockup_err=0. A pending request is lost.
- LFSR advance: lfsr <= {lfsr[WIDTH-2:0], ~^(lfsr & TAPS)}. With the defaults, the period is 15 and the sequence from 0000 is 0001, 0011, 0111, 1110, 1101, 1011, 0110, 1100, 1001, 0010, 0101, 1010, 0100, 1000, 0000. All-ones is the lock-up state.
- All outputs are registered.
- FSM states: IDLE, STEP, GRANT.
- IDLE, seed_load=1 (priority over req): lfsr<=seed and stay in IDLE. If seed is all-ones: lfsr<=0 and lockup_err<=1 instead.
- IDLE, seed_load=0, req!=0: pick the winner as the first set bit at or after rr_ptr, wrapping modulo NREQ. Latch the winner, cnt<=STEPS-1, go to STEP.
- IDLE, otherwise: LFSR holds (see Optional Feature).
- STEP: advance the LFSR every cycle. If cnt==0, go to GRANT; else cnt--. The winner's req is re-sampled on the last STEP cycle.
- GRANT, winner still requesting: the GRANT cycle shows gnt=onehot(winner), rnd_valid=1, rnd_data=lfsr. rr_ptr<=(winner+1) mod NREQ. Return to IDLE.
- GRANT, winner dropped req: gnt=0, rnd_valid=0, rnd_data unchanged, rr_ptr unchanged. The advances are kept. Return to IDLE.
- Latency: req sampled at edge E in IDLE → gnt/rnd_valid high between edges E+STEPS and E+STEPS+1. Each grant occupies STEPS+2 cycles; there are no back-to-back grants.
- Requests arriving during STEP/GRANT wait for IDLE. Non-winner req changes do not affect the current transaction.
- seed_load outside IDLE is ignored, with no error.
- lockup_err is cleared only by rst.
- Invariant: gnt is 0 or one-hot, and rnd_valid == |gnt.

Optional Feature:
LFSR_FREERUN_EN
- Defined: the LFSR also advances every IDLE cycle in which seed_load=0, so consumers cannot predict the next word from the grant history.
- Undefined: the LFSR holds in IDLE; advances occur only in STEP. This gives deterministic values per grant and is the default for the test plan below.

Test Plan:
Defaults, LFSR_FREERUN_EN undefined.
1. Reset, then req=0001 → gnt=0001 two edges after acceptance, rnd_data=0011, rnd_valid=1 for exactly one cycle, rr_ptr=1.
2. From reset, req=1111 held → grants 0001, 0010, 0100, 1000 with rnd_data 0011, 1110, 1011, 1100, each 4 cycles apart. busy is low one cycle between grants.
3. In IDLE, seed_load=1 with seed=1010 and req=0010 in the same cycle → seed loaded with no grant started; the next edge starts arbitration; gnt=0010 with rnd_data=1000.
4. seed_load with seed=1111 → lfsr=0000, lockup_err=1, which stays set through subsequent grants; the next single request yields rnd_data=0011.
5. req=0100 accepted, then deasserted during STEP → no gnt, rnd_valid=0, rnd_data unchanged, rr_ptr unchanged. A later req=0100 yields the word two further advances on.
6. rst asserted mid-STEP → gnt, rnd_valid, busy and lfsr are 0 immediately (asynchronously). After release, req=0001 reproduces scenario 1.

Source files
------------

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one XNOR Fibonacci LFSR between NREQ consumers, with seed
// sequencing and lock-up protection. Define LFSR_FREERUN_EN to let the LFSR also advance while idle.
module lfsr_share_ctrl #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS = 4'b1100,
    parameter int              NREQ  = 4,
    parameter int              STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic             lockup_err
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;

    state_t          state;
    logic [WIDTH-1:0] lfsr;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic [CW-1:0]   cnt;

    function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ~^(v & TAPS)};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        int idx;
        pick = rr_ptr;
        idx  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) pick = PW'(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= '0;
            rr_ptr     <= '0;
            winner     <= '0;
            cnt        <= '0;
            gnt        <= '0;
            rnd_valid  <= 1'b0;
            rnd_data   <= '0;
            busy       <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        // An all-ones seed would freeze an XNOR LFSR; substitute zero and flag it.
                        if (&seed) begin
                            lfsr       <= '0;
                            lockup_err <= 1'b1;
                        end else begin
                            lfsr <= seed;
                        end
                    end else begin
`ifdef LFSR_FREERUN_EN
                        lfsr <= lfsr_adv(lfsr);
`else
                        lfsr <= lfsr;
`endif
                        if (|req) begin
                            winner <= pick;
                            cnt    <= CW'(STEPS - 1);
                            busy   <= 1'b1;
                            state  <= STEP;
                        end
                    end
                end
                STEP: begin
                    lfsr <= lfsr_adv(lfsr);
                    if (cnt == '0) begin
                        state <= GRANT;
                        if (req[winner]) begin
                            gnt       <= onehot(winner);
                            rnd_valid <= 1'b1;
                            rnd_data  <= lfsr_adv(lfsr);
                            rr_ptr    <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GRANT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Directed bench for lfsr_share_ctrl with default parameters and the LFSR held while idle.
module tb_lfsr_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic       seed_load;
    logic [3:0] seed;
    logic       busy;
    logic       lockup_err;

    int npass  = 0;
    int ntotal = 0;

    lfsr_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .seed_load  (seed_load),
        .seed       (seed),
        .busy       (busy),
        .lockup_err (lockup_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0; seed_load = 1'b0; seed = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; seed_load = 1'b0; seed = '0;
        #1;
        ntotal++; if ({gnt, rnd_valid, rnd_data, busy, lockup_err} !== 11'd0)
            $display("FAIL reset_outputs: got %b required 0", {gnt, rnd_valid, rnd_data, busy, lockup_err});
        else npass++;
        ntotal++; if (dut.lfsr !== 4'b0000) $display("FAIL reset_lfsr: got %b required 0000", dut.lfsr); else npass++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        ntotal++; if (busy !== 1'b1 || gnt !== 4'b0000) $display("FAIL t1_accept: busy=%b gnt=%b required 1/0000", busy, gnt); else npass++;
        tick();
        ntotal++; if (gnt !== 4'b0000) $display("FAIL t1_step_gnt: got %b required 0000", gnt); else npass++;
        tick();
        ntotal++; if (gnt !== 4'b0001 || rnd_valid !== 1'b1) $display("FAIL t1_gnt: gnt=%b vld=%b required 0001/1", gnt, rnd_valid); else npass++;
        ntotal++; if (rnd_data !== 4'b0011) $display("FAIL t1_data: got %b required 0011", rnd_data); else npass++;
        req = 4'b0000;
        tick();
        ntotal++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t1_after: gnt=%b vld=%b busy=%b required 0000/0/0", gnt, rnd_valid, busy); else npass++;
        ntotal++; if (rnd_data !== 4'b0011) $display("FAIL t1_hold: got %b required 0011", rnd_data); else npass++;
        ntotal++; if (dut.rr_ptr !== 2'd1) $display("FAIL t1_rrptr: got %0d required 1", dut.rr_ptr); else npass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_d [4] = '{4'b0011, 4'b1110, 4'b1011, 4'b1100};
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            tick();
            tick();
            ntotal++; if (gnt !== exp_g[g] || rnd_valid !== 1'b1) $display("FAIL t2_gnt%0d: got %b required %b", g, gnt, exp_g[g]); else npass++;
            ntotal++; if (rnd_data !== exp_d[g]) $display("FAIL t2_data%0d: got %b required %b", g, rnd_data, exp_d[g]); else npass++;
            tick();
            ntotal++; if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL t2_gap%0d: busy=%b gnt=%b required 0/0000", g, busy, gnt); else npass++;
        end
        req = 4'b0000;
        ntotal++; if (dut.rr_ptr !== 2'd0) $display("FAIL t2_wrap: got %0d required 0", dut.rr_ptr); else npass++;
        tick();
    endtask

    task automatic test_seed_priority();
        do_reset();
        seed_load = 1'b1; seed = 4'b1010; req = 4'b0010;
        tick();
        ntotal++; if (busy !== 1'b0 || dut.lfsr !== 4'b1010) $display("FAIL t3_seed: busy=%b lfsr=%b required 0/1010", busy, dut.lfsr); else npass++;
        seed_load = 1'b0;
        tick();
        ntotal++; if (busy !== 1'b1) $display("FAIL t3_accept: busy=%b required 1", busy); else npass++;
        tick();
        tick();
        ntotal++; if (gnt !== 4'b0010 || rnd_data !== 4'b1000) $display("FAIL t3_gnt: gnt=%b data=%b required 0010/1000", gnt, rnd_data); else npass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_lockup();
        do_reset();
        seed_load = 1'b1; seed = 4'b1111;
        tick();
        ntotal++; if (lockup_err !== 1'b1 || dut.lfsr !== 4'b0000) $display("FAIL t4_lock: err=%b lfsr=%b required 1/0000", lockup_err, dut.lfsr); else npass++;
        seed_load = 1'b0; req = 4'b0001;
        tick(); tick(); tick();
        ntotal++; if (gnt !== 4'b0001 || rnd_data !== 4'b0011) $display("FAIL t4_gnt: gnt=%b data=%b required 0001/0011", gnt, rnd_data); else npass++;
        req = 4'b0010;
        tick();
        tick(); tick(); tick();
        ntotal++; if (gnt !== 4'b0010 || rnd_data !== 4'b1110) $display("FAIL t4_gnt2: gnt=%b data=%b required 0010/1110", gnt, rnd_data); else npass++;
        ntotal++; if (lockup_err !== 1'b1) $display("FAIL t4_sticky: got %b required 1", lockup_err); else npass++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000; seed_load = 1'b1; seed = 4'b0101;
        tick();
        seed_load = 1'b0;
        tick();
        ntotal++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || rnd_data !== 4'b0000) $display("FAIL t5_nogrant: gnt=%b vld=%b data=%b required 0000/0/0000", gnt, rnd_valid, rnd_data); else npass++;
        tick();
        ntotal++; if (dut.rr_ptr !== 2'd0 || dut.lfsr !== 4'b0011) $display("FAIL t5_state: rr=%0d lfsr=%b required 0/0011", dut.rr_ptr, dut.lfsr); else npass++;
        req = 4'b0100;
        tick(); tick(); tick();
        ntotal++; if (gnt !== 4'b0100 || rnd_data !== 4'b1110) $display("FAIL t5_gnt: gnt=%b data=%b required 0100/1110", gnt, rnd_data); else npass++;
        req = 4'b0000;
        tick();
        ntotal++; if (dut.rr_ptr !== 2'd3) $display("FAIL t5_rrptr: got %0d required 3", dut.rr_ptr); else npass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        ntotal++; if (busy !== 1'b1 || dut.lfsr !== 4'b0001) $display("FAIL t6_pre: busy=%b lfsr=%b required 1/0001", busy, dut.lfsr); else npass++;
        #2 rst = 1'b1;
        #1;
        ntotal++; if (busy !== 1'b0 || gnt !== 4'b0000 || rnd_valid !== 1'b0 || dut.lfsr !== 4'b0000)
            $display("FAIL t6_async: busy=%b gnt=%b vld=%b lfsr=%b required all 0", busy, gnt, rnd_valid, dut.lfsr);
        else npass++;
        @(negedge clk);
        rst = 1'b0;
        tick(); tick(); tick();
        ntotal++; if (gnt !== 4'b0001 || rnd_data !== 4'b0011) $display("FAIL t6_regrant: gnt=%b data=%b required 0001/0011", gnt, rnd_data); else npass++;
        req = 4'b0000;
        tick();
        ntotal++; if (dut.rr_ptr !== 2'd1) $display("FAIL t6_rrptr: got %0d required 1", dut.rr_ptr); else npass++;
    endtask

    // gnt must always be zero or one-hot, and rnd_valid must track it.
    always @(negedge clk) begin
        if (!rst && (((gnt & (gnt - 4'd1)) != 4'd0) || (rnd_valid !== (|gnt))))
            $display("FAIL invariant: gnt=%b vld=%b", gnt, rnd_valid);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_seed_priority();
        test_lockup();
        test_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
